// File: rtl/fifo_wr_arbiter_if.sv
// Requester-to-FIFO write bus for fifo_wr_arbiter.
// The arbiter drives through the master modport; requesters and the FIFO sit on the slave side.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          wfull;
  logic                          winc;
  logic [DATA_WIDTH-1:0]         wdata;
  logic [GW-1:0]                 grant_id;
  logic                          busy;

  modport master (
    input  req_valid, req_data, wfull,
    output req_ready, winc, wdata, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, wfull,
    input  req_ready, winc, wdata, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets one requester at a time burst up to MAX_BURST words into a FIFO.
// The holder keeps the grant until its burst completes or it drops valid.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic               wclk,
  input  logic               wrst_n,
  fifo_wr_arbiter_if.master  bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
  localparam logic [GW-1:0] LAST_REQ  = GW'(NUM_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [GW-1:0]   grant_q;
  logic [GW-1:0]   last_gnt;
  logic [GW-1:0]   winner;
  logic [BW-1:0]   beat_cnt;
  logic            any_valid;
  logic            holder_valid;
  logic            beat;
  logic            grant_end;

  assign any_valid    = |bus.req_valid;
  assign holder_valid = bus.req_valid[grant_q];
  assign beat         = (state == GRANT) && holder_valid && !bus.wfull;
  assign grant_end    = (state == GRANT) &&
                        (!holder_valid || (beat && (beat_cnt == LAST_BEAT)));

  // Scan starts just past the last holder, so it gets the lowest priority.
  always_comb begin
    logic found;
    int   idx;
    winner = last_gnt;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_gnt) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        winner = GW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = GRANT;
      GRANT:   if (grant_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      grant_q  <= '0;
      last_gnt <= LAST_REQ;
      beat_cnt <= '0;
    end else if ((state == IDLE) && any_valid) begin
      grant_q  <= winner;
      beat_cnt <= '0;
    end else if (grant_end) begin
      last_gnt <= grant_q;
      beat_cnt <= '0;
    end else if (beat) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // wdata follows the holder's slice every cycle; only winc qualifies it.
  always_comb begin
    bus.req_ready          = '0;
    bus.req_ready[grant_q] = beat;
    bus.winc               = beat;
    bus.wdata              = bus.req_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    bus.grant_id           = grant_q;
    bus.busy               = (state == GRANT);
  end
endmodule
